// File: rtl/screen_selector.sv
// screen_selector: top-level game-flow FSM (START -> PLAY -> FINISH), start-button
// debounce and frame-aligned selection of the start/game/finish VGA streams.
module screen_selector #(
   parameter int unsigned DEBOUNCE_CYCLES   = 650_000,
   parameter int unsigned FINISH_MIN_FRAMES = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        game_over,
   input  logic [10:0] vga_start_in_hcount,
   input  logic [10:0] vga_start_in_vcount,
   input  logic        vga_start_in_hsync,
   input  logic        vga_start_in_vsync,
   input  logic        vga_start_in_hblnk,
   input  logic        vga_start_in_vblnk,
   input  logic [11:0] vga_start_in_rgb,
   input  logic [10:0] vga_game_in_hcount,
   input  logic [10:0] vga_game_in_vcount,
   input  logic        vga_game_in_hsync,
   input  logic        vga_game_in_vsync,
   input  logic        vga_game_in_hblnk,
   input  logic        vga_game_in_vblnk,
   input  logic [11:0] vga_game_in_rgb,
   input  logic [10:0] vga_fin_in_hcount,
   input  logic [10:0] vga_fin_in_vcount,
   input  logic        vga_fin_in_hsync,
   input  logic        vga_fin_in_vsync,
   input  logic        vga_fin_in_hblnk,
   input  logic        vga_fin_in_vblnk,
   input  logic [11:0] vga_fin_in_rgb,
   output logic [10:0] vga_out_hcount,
   output logic [10:0] vga_out_vcount,
   output logic        vga_out_hsync,
   output logic        vga_out_vsync,
   output logic        vga_out_hblnk,
   output logic        vga_out_vblnk,
   output logic [11:0] vga_out_rgb,
   output logic        game_rst,
   output logic        game_active,
   output logic [1:0]  screen_state
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned FIN_W = 7;

   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_PLAY   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t           state;
   state_t           sel;
   logic [FIN_W-1:0] fin_frames;
   logic             sync1;
   logic             btn_sync;
   logic             btn_stable;
   logic             btn_prev;
   logic             armed;
   logic [1:0]       prime;
   logic [CNT_W-1:0] cnt;
   logic             press;
   logic             frame_tick;
   logic             unused_timing;

   // The other streams share the start stream's timing; only their rgb is used.
   assign unused_timing = ^{vga_game_in_hcount, vga_game_in_vcount, vga_game_in_hsync,
                            vga_game_in_vsync, vga_game_in_hblnk, vga_game_in_vblnk,
                            vga_fin_in_hcount, vga_fin_in_vcount, vga_fin_in_hsync,
                            vga_fin_in_vsync, vga_fin_in_hblnk, vga_fin_in_vblnk};

   // Synchronize and debounce; a press needs the button seen released since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b0;
         btn_sync   <= 1'b0;
         btn_stable <= 1'b0;
         btn_prev   <= 1'b0;
         armed      <= 1'b0;
         prime      <= 2'b00;
         cnt        <= '0;
      end else begin
         sync1    <= btn_start;
         btn_sync <= sync1;
         prime    <= {prime[0], 1'b1};
         btn_prev <= btn_stable;
         if (prime[1] && !btn_sync && !btn_stable)
            armed <= 1'b1;
         if (btn_sync == btn_stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_stable <= btn_sync;
            cnt        <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign press      = btn_stable & ~btn_prev & armed;
   // vga_out_vblnk is the previous cycle's input vblnk.
   assign frame_tick = vga_start_in_vblnk & ~vga_out_vblnk;

   // Game-flow FSM with registered game_rst / game_active.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_START;
         game_rst    <= 1'b0;
         game_active <= 1'b0;
         fin_frames  <= '0;
      end else begin
         game_rst <= 1'b0;
         case (state)
            ST_START: begin
               if (press) begin
                  state       <= ST_PLAY;
                  game_rst    <= 1'b1;
                  game_active <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (game_over) begin
                  state       <= ST_FINISH;
                  game_active <= 1'b0;
                  fin_frames  <= '0;
               end
            end
            ST_FINISH: begin
               if (press && (fin_frames >= FIN_W'(FINISH_MIN_FRAMES)))
                  state <= ST_START;
               else if (frame_tick && (fin_frames < FIN_W'(FINISH_MIN_FRAMES)))
                  fin_frames <= fin_frames + FIN_W'(1);
            end
            default: begin
               state       <= ST_START;
               game_active <= 1'b0;
            end
         endcase
      end
   end

   assign screen_state = state;

   // Output register; source switches only on a frame boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel            <= ST_START;
         vga_out_hcount <= '0;
         vga_out_vcount <= '0;
         vga_out_hsync  <= 1'b0;
         vga_out_vsync  <= 1'b0;
         vga_out_hblnk  <= 1'b0;
         vga_out_vblnk  <= 1'b0;
         vga_out_rgb    <= '0;
      end else begin
         if (frame_tick)
            sel <= state;
         vga_out_hcount <= vga_start_in_hcount;
         vga_out_vcount <= vga_start_in_vcount;
         vga_out_hsync  <= vga_start_in_hsync;
         vga_out_vsync  <= vga_start_in_vsync;
         vga_out_hblnk  <= vga_start_in_hblnk;
         vga_out_vblnk  <= vga_start_in_vblnk;
         if (vga_start_in_hblnk || vga_start_in_vblnk) begin
            vga_out_rgb <= '0;
         end else begin
            case (sel)
               ST_PLAY:   vga_out_rgb <= vga_game_in_rgb;
               ST_FINISH: vga_out_rgb <= vga_fin_in_rgb;
               default:   vga_out_rgb <= vga_start_in_rgb;
            endcase
         end
      end
   end

endmodule
